// File: rtl/sl_pkg.sv
// Shared types for the two-line serial transmitter.
// FSM state encoding and line-level constants.
package sl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_ACT,
    BIT_GAP,
    PAR,
    PAR_GAP,
    STOP,
    STOP_GAP
  } sl_state_e;

  localparam logic IDLE_LVL = 1'b1;
  localparam logic STOP_LVL = 1'b0;

endpackage

// File: rtl/sl_fifo.sv
// Show-ahead word FIFO feeding the line transmitter.
// Ports: push/wdata in, pop/rdata out, full/empty/level status.
module sl_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sl_tx_stream.sv
// Two-line active-low serial word transmitter with input FIFO.
// Ports: wr_* FIFO push, len_m1/half_period frame setup, sl0/sl1 lines, busy/word_done/fifo_level status.
module sl_tx_stream
  import sl_pkg::*;
#(
  parameter int MAX_BITS   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [MAX_BITS-1:0]             wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [$clog2(MAX_BITS)-1:0]     len_m1,
  input  logic [DIV_W-1:0]                half_period,
  output logic                            sl0,
  output logic                            sl1,
  output logic                            busy,
  output logic                            word_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int LW = $clog2(MAX_BITS);

  sl_state_e         state;
  sl_state_e         state_n;
  logic              rdy_en;
  logic              full;
  logic              empty;
  logic              pop;
  logic              ph_end;
  logic [MAX_BITS-1:0] head;
  logic [MAX_BITS-1:0] shreg;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     bit_cnt;
  logic [DIV_W-1:0]  h_q;
  logic [DIV_W-1:0]  ph_cnt;
  logic              par0;
  logic              par1;

  // Held low for one edge after reset so wr_ready comes up on the first clock.
  assign wr_ready = rdy_en & ~full;
  assign ph_end   = (ph_cnt == h_q);

  sl_fifo #(
    .WIDTH(MAX_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (wr_valid & wr_ready),
    .pop    (pop),
    .wdata  (wr_data),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = BIT_ACT;
        end
      end
      BIT_ACT:  if (ph_end) state_n = BIT_GAP;
      BIT_GAP: begin
        if (ph_end) state_n = (bit_cnt == len_q) ? PAR : BIT_ACT;
      end
      PAR:      if (ph_end) state_n = PAR_GAP;
      PAR_GAP:  if (ph_end) state_n = STOP;
      STOP:     if (ph_end) state_n = STOP_GAP;
      STOP_GAP: begin
        if (ph_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = BIT_ACT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rdy_en  <= 1'b0;
      shreg   <= '0;
      len_q   <= '0;
      h_q     <= '0;
      bit_cnt <= '0;
      ph_cnt  <= '0;
      par0    <= 1'b1;
      par1    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_n;
      if (pop) begin
        shreg   <= head;
        len_q   <= len_m1;
        h_q     <= half_period;
        bit_cnt <= '0;
        ph_cnt  <= '0;
        par0    <= 1'b1;
        par1    <= 1'b0;
      end else if (state != IDLE) begin
        ph_cnt <= ph_end ? '0 : ph_cnt + 1'b1;
        if (ph_end && state == BIT_ACT) begin
          par0 <= par0 ^ ~shreg[0];
          par1 <= par1 ^ shreg[0];
        end
        if (ph_end && state == BIT_GAP) begin
          shreg <= shreg >> 1;
          if (bit_cnt != len_q) bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Line outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sl0       <= IDLE_LVL;
      sl1       <= IDLE_LVL;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      busy      <= (state != IDLE);
      word_done <= (state == STOP_GAP) && ph_end;
      unique case (state)
        BIT_ACT: begin
          sl0 <= shreg[0];
          sl1 <= ~shreg[0];
        end
        PAR: begin
          sl0 <= par0;
          sl1 <= par1;
        end
        STOP: begin
          sl0 <= STOP_LVL;
          sl1 <= STOP_LVL;
        end
        default: begin
          sl0 <= IDLE_LVL;
          sl1 <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule
